// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream load handshake plus imem write port and loader status.
// master drives the stream side, slave is the loader itself.
interface imem_loader_if #(
    parameter int N  = 32,
    parameter int AW = 5
);
    logic          start;
    logic [AW:0]   num_words;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          cpu_hold;
    logic          err;

    modport master (
        output start, num_words, byte_in, byte_valid,
        input  byte_ready, we, waddr, wdata, busy, done, cpu_hold, err
    );

    modport slave (
        input  start, num_words, byte_in, byte_valid,
        output byte_ready, we, waddr, wdata, busy, done, cpu_hold, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into N-bit words written to imem from address 0,
// holding the CPU in reset until done. Define CHECKSUM_EN for a trailing 8-bit sum byte check on err.
module imem_loader #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam int BPW = N / 8;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd3;
    localparam logic [2:0] S_TAIL  = S_CHK;
`else
    localparam logic [2:0] S_TAIL  = S_DONE;
`endif

    logic [2:0]    state, nxt;
    logic [AW:0]   nwords, wcnt, clamp;
    logic [BW-1:0] bcnt;
    logic [N-1:0]  part_q, asm_w, wdata_q;
    logic [AW-1:0] waddr_q;
    logic          we_q, done_q, hold_q, ready, acc, last_byte, last_word;

`ifdef CHECKSUM_EN
    assign ready = state == S_RECV || state == S_CHK;
`else
    assign ready = state == S_RECV;
`endif

    always_comb begin
        clamp     = bus.num_words > DEPTH ? DEPTH : bus.num_words;
        acc       = bus.byte_valid && ready;
        last_byte = bcnt == BW'(BPW - 1);
        last_word = wcnt + 1'b1 == nwords;
        // the final byte bypasses the partial register so the word is complete on entry to WRITE
        asm_w = part_q;
        asm_w[8*bcnt +: 8] = bus.byte_in;
        case (state)
            S_IDLE:  nxt = bus.start ? (clamp == '0 ? S_DONE : S_RECV) : S_IDLE;
            S_RECV:  nxt = acc && last_byte ? S_WRITE : S_RECV;
            S_WRITE: nxt = last_word ? S_TAIL : S_RECV;
`ifdef CHECKSUM_EN
            S_CHK:   nxt = acc ? S_DONE : S_CHK;
`endif
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            nwords  <= '0;
            wcnt    <= '0;
            bcnt    <= '0;
            part_q  <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state  <= nxt;
            we_q   <= nxt == S_WRITE;
            done_q <= nxt == S_DONE;
            if (state == S_IDLE && bus.start) begin
                nwords <= clamp;
                wcnt   <= '0;
                bcnt   <= '0;
                hold_q <= 1'b1;
            end
            if (state == S_RECV && acc) begin
                part_q[8*bcnt +: 8] <= bus.byte_in;
                bcnt <= last_byte ? '0 : bcnt + 1'b1;
            end
            if (nxt == S_WRITE) begin
                wdata_q <= asm_w;
                waddr_q <= wcnt[AW-1:0];
            end
            if (state == S_WRITE) wcnt <= wcnt + 1'b1;
            if (state == S_DONE) hold_q <= 1'b0;
        end
    end

`ifdef CHECKSUM_EN
    logic [7:0] sum;
    logic       err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (acc && state == S_RECV) begin
            sum <= sum + bus.byte_in;
        end else if (acc && state == S_CHK) begin
            err_q <= bus.byte_in != sum;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.byte_ready = ready;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy       = state != S_IDLE;
    assign bus.done       = done_q;
    assign bus.cpu_hold   = hold_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader; expected writes come from
// a byte-list model (word i = bytes 4i..4i+3, first byte least significant, clamp to 32 words).
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int N = 32, AW = 5;
    logic clk = 1'b0;
    logic reset;
    int checks = 0, errors = 0;
    int done_cnt = 0, bad_acc = 0, hold_bad = 0;
    logic [AW-1:0] wa_q[$];
    logic [N-1:0]  wd_q[$];

    imem_loader_if #(.N(N), .AW(AW)) bus ();
    imem_loader #(.N(N), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.we) begin
            wa_q.push_back(bus.waddr);
            wd_q.push_back(bus.wdata);
        end
        if (bus.done) done_cnt++;
        if (bus.we && bus.byte_valid && bus.byte_ready) bad_acc++;
        if (bus.busy && !bus.cpu_hold) hold_bad++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] word_of(input logic [7:0] d[$], input int i);
        logic [N-1:0] w = '0;
        for (int k = 0; k < N / 8; k++) w = w + (N'(d[i * (N / 8) + k]) << (8 * k));
        return w;
    endfunction

    function automatic logic [7:0] sum_of(input logic [7:0] d[$]);
        int s = 0;
        foreach (d[i]) s += int'(d[i]);
        return 8'(s % 256);
    endfunction

    task automatic rand_bytes(input int cnt, output logic [7:0] d[$]);
        d.delete();
        repeat (cnt) d.push_back(8'($urandom));
    endtask

    task automatic pulse_start(input int n);
        bus.start     = 1'b1;
        bus.num_words = 6'(n);
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.num_words = 6'($urandom);
    endtask

    task automatic drive_stream(input logic [7:0] data[$], input bit toggle, output bit tmo);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b1;
        tmo = 1'b0;
        while (i < data.size()) begin
            bus.byte_valid = toggle ? ph : 1'b1;
            bus.byte_in    = bus.byte_valid ? data[i] : 8'($urandom);
            @(negedge clk);
            if (bus.byte_valid && bus.byte_ready) i++;
            @(posedge clk); #1;
            ph = !ph;
            if (++cyc > 4000) begin
                tmo = 1'b1;
                break;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit tmo);
        int c = 0;
        while (bus.busy && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        tmo = bus.busy;
    endtask

    task automatic do_load(input int n, input logic [7:0] d[$], input bit toggle, output bit tmo);
        logic [7:0] s[$];
        bit t1, t2;
        s = d;
`ifdef CHECKSUM_EN
        if (n > 0) s.push_back(sum_of(d));
`endif
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        pulse_start(n);
        drive_stream(s, toggle, t1);
        wait_idle(t2);
        tmo = t1 || t2;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.byte_ready, bus.we, bus.busy, bus.done, bus.cpu_hold, bus.err} !== 6'b000010) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000010",
                     {bus.byte_ready, bus.we, bus.busy, bus.done, bus.cpu_hold, bus.err});
        end
        checks++;
        if (bus.waddr !== '0 || bus.wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: got %0d/%h want 0/0", bus.waddr, bus.wdata);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.byte_ready, bus.busy, bus.cpu_hold} !== 3'b001) begin
            errors++;
            $display("FAIL reset_idle: got %b want 001", {bus.byte_ready, bus.busy, bus.cpu_hold});
        end
    endtask

    task automatic test_single;
        logic [7:0] d[$];
        bit t;
        d = '{8'h13, 8'h05, 8'h00, 8'h00};
        hold_bad = 0;
        do_load(1, d, 1'b0, t);
        checks++;
        if (t) begin errors++; $display("FAIL single_timeout: got busy want idle"); end
        checks++;
        if (wa_q.size() !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d want 1", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 5'd0 || wd_q[0] !== 32'h00000513) begin
                errors++;
                $display("FAIL single_write: got %0d/%h want 0/00000513", wa_q[0], wd_q[0]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt); end
        checks++;
        if (bus.cpu_hold !== 1'b0 || hold_bad !== 0) begin
            errors++;
            $display("FAIL single_hold: got hold=%b early_release=%0d want 0/0", bus.cpu_hold, hold_bad);
        end
    endtask

    task automatic test_toggle;
        logic [7:0] d[$];
        bit t;
        rand_bytes(12, d);
        bad_acc = 0;
        do_load(3, d, 1'b1, t);
        checks++;
        if (t) begin errors++; $display("FAIL toggle_timeout: got busy want idle"); end
        checks++;
        if (wa_q.size() !== 3) begin errors++; $display("FAIL toggle_count: got %0d want 3", wa_q.size()); end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== word_of(d, i)) begin
                errors++;
                $display("FAIL toggle_write%0d: got %0d/%h want %0d/%h", i, wa_q[i], wd_q[i], i, word_of(d, i));
            end
        end
        checks++;
        if (bad_acc !== 0) begin errors++; $display("FAIL toggle_write_accept: got %0d want 0", bad_acc); end
    endtask

    task automatic test_zero;
        logic [7:0] d[$];
        bit t;
        d.delete();
        do_load(0, d, 1'b0, t);
        checks++;
        if (t || done_cnt !== 1) begin
            errors++;
            $display("FAIL zero_done: got timeout=%b done=%0d want 0/1", t, done_cnt);
        end
        checks++;
        if (wa_q.size() !== 0 || bus.cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL zero_writes: got %0d/hold=%b want 0/0", wa_q.size(), bus.cpu_hold);
        end
    endtask

    task automatic test_clamp;
        logic [7:0] d[$];
        bit t;
        int bad = 0;
        rand_bytes(32 * 4, d);
        do_load(40, d, 1'b0, t);
        checks++;
        if (t || wa_q.size() !== 32) begin
            errors++;
            $display("FAIL clamp_count: got timeout=%b writes=%0d want 0/32", t, wa_q.size());
        end
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== AW'(i) || wd_q[i] !== word_of(d, i)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL clamp_data: got %0d bad writes want 0", bad); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.waddr !== 5'd31 || bus.wdata !== word_of(d, 31) || bus.we !== 1'b0) begin
            errors++;
            $display("FAIL clamp_hold: got %0d/%h we=%b want 31/%h we=0", bus.waddr, bus.wdata, bus.we, word_of(d, 31));
        end
    endtask

    task automatic test_abort;
        logic [7:0] d[$];
        logic [7:0] first[$];
        bit t;
        rand_bytes(8, d);
        first = '{d[0], d[1]};
        wa_q.delete();
        wd_q.delete();
        pulse_start(2);
        drive_stream(first, 1'b0, t);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.byte_ready, bus.we, bus.busy, bus.done, bus.cpu_hold, bus.err} !== 6'b000010 ||
            bus.waddr !== '0 || bus.wdata !== '0) begin
            errors++;
            $display("FAIL abort_reset: got %b %0d/%h want 000010 0/0",
                     {bus.byte_ready, bus.we, bus.busy, bus.done, bus.cpu_hold, bus.err}, bus.waddr, bus.wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (wa_q.size() !== 0) begin errors++; $display("FAIL abort_nowrite: got %0d want 0", wa_q.size()); end
        do_load(2, d, 1'b0, t);
        checks++;
        if (t || wa_q.size() !== 2) begin
            errors++;
            $display("FAIL abort_reload_count: got timeout=%b writes=%0d want 0/2", t, wa_q.size());
        end
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== word_of(d, i)) begin
                errors++;
                $display("FAIL abort_reload%0d: got %0d/%h want %0d/%h", i, wa_q[i], wd_q[i], i, word_of(d, i));
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [7:0] d[$];
        logic [7:0] head[$];
        logic [7:0] rest[$];
        bit t1, t2, t3;
        rand_bytes(8, d);
        head = '{d[0], d[1]};
        for (int i = 2; i < 8; i++) rest.push_back(d[i]);
`ifdef CHECKSUM_EN
        rest.push_back(sum_of(d));
`endif
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        pulse_start(2);
        drive_stream(head, 1'b0, t1);
        pulse_start(5);
        drive_stream(rest, 1'b0, t2);
        wait_idle(t3);
        checks++;
        if (t1 || t2 || t3 || wa_q.size() !== 2 || done_cnt !== 1) begin
            errors++;
            $display("FAIL ignored_count: got timeout=%b writes=%0d done=%0d want 0/2/1",
                     t1 || t2 || t3, wa_q.size(), done_cnt);
        end
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== word_of(d, i)) begin
                errors++;
                $display("FAIL ignored_write%0d: got %0d/%h want %0d/%h", i, wa_q[i], wd_q[i], i, word_of(d, i));
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] d[$];
        bit t;
        int n, bad;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 8);
            rand_bytes(n * 4, d);
            do_load(n, d, 1'($urandom), t);
            bad = 0;
            for (int i = 0; i < wa_q.size(); i++)
                if (wa_q[i] !== AW'(i) || wd_q[i] !== word_of(d, i)) bad++;
            checks++;
            if (t || wa_q.size() !== n || bad !== 0 || done_cnt !== 1) begin
                errors++;
                $display("FAIL random%0d: got timeout=%b writes=%0d bad=%0d done=%0d want 0/%0d/0/1",
                         it, t, wa_q.size(), bad, done_cnt, n);
            end
        end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum;
        logic [7:0] d[$];
        logic [7:0] s[$];
        bit t1, t2;
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int pass = 0; pass < 2; pass++) begin
            s = d;
            s.push_back(pass == 1 ? 8'h0B : 8'h0A);
            pulse_start(1);
            drive_stream(s, 1'b0, t1);
            wait_idle(t2);
            checks++;
            if (t1 || t2 || bus.err !== 1'(pass) || bus.wdata !== 32'h04030201) begin
                errors++;
                $display("FAIL checksum_pass%0d: got timeout=%b err=%b data=%h want 0/%0d/04030201",
                         pass, t1 || t2, bus.err, bus.wdata, pass);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL checksum_sticky: got %b want 1", bus.err); end
        pulse_start(1);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL checksum_clear: got %b want 0", bus.err); end
        s = d;
        s.push_back(8'h0A);
        drive_stream(s, 1'b0, t1);
        wait_idle(t2);
        checks++;
        if (t1 || t2 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL checksum_reload: got timeout=%b err=%b want 0/0", t1 || t2, bus.err);
        end
    endtask
`else
    task automatic test_checksum;
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL err_tied: got %b want 0", bus.err); end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.num_words  = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        test_reset();
        test_single();
        test_toggle();
        test_zero();
        test_clamp();
        test_abort();
        test_start_ignored();
        test_random();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
